// File: rtl/minhash_topk_sorter_if.sv
// Sorter handshake bundle: beat stream in, sorted MinHash sketch out.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the result side.
interface minhash_topk_sorter_if #(
  parameter int SIG_W = 32,
  parameter int IDX_W = 8,
  parameter int TOP_K = 4
);
  localparam int CNT_W = $clog2(TOP_K + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic [SIG_W-1:0]         in_signature;
  logic [IDX_W-1:0]         in_index;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [TOP_K*IDX_W-1:0]   out_indices;
  logic [TOP_K*SIG_W-1:0]   out_signatures;
  logic [CNT_W-1:0]         out_count;

  // Upstream hasher / downstream extender side
  modport master (
    output in_valid, in_signature, in_index, in_last, out_ready,
    input  in_ready, out_valid, out_indices, out_signatures, out_count
  );

  // Sorter side
  modport slave (
    input  in_valid, in_signature, in_index, in_last, out_ready,
    output in_ready, out_valid, out_indices, out_signatures, out_count
  );
endinterface

// File: rtl/minhash_topk_sorter.sv
// Keeps the TOP_K smallest {signature,index} pairs of a frame, sorted ascending (MinHash sketch).
// Latency: one beat inserted per cycle; result valid 1 cycle after the last beat, one bubble between frames.
// Backpressure: in_ready low while a result is held; result held stable until out_ready.
module minhash_topk_sorter #(
  parameter int SIG_W = 32,
  parameter int IDX_W = 8,
  parameter int TOP_K = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  minhash_topk_sorter_if.slave bus
);
  localparam int CNT_W = $clog2(TOP_K + 1);

  typedef enum logic {COLLECT = 1'b0, OUTPUT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q [TOP_K];
  logic [SIG_W-1:0] sig_d [TOP_K];
  logic [IDX_W-1:0] idx_q [TOP_K];
  logic [IDX_W-1:0] idx_d [TOP_K];
  logic [TOP_K-1:0] vld_q, vld_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Insertion helpers: le marks occupied slots that stay ahead of the new beat
  // (ties keep the earlier arrival first); prev_le[i] is le of the slot below.
  logic             accept;
  logic [TOP_K-1:0] le;
  logic [TOP_K-1:0] prev_le;
  logic [SIG_W-1:0] sh_sig [TOP_K];
  logic [IDX_W-1:0] sh_idx [TOP_K];

  // Compare the incoming signature against every slot in parallel
  always_comb begin
    accept = bus.in_valid && in_ready_q && (state_q == COLLECT);
    le      = '0;
    prev_le = '0;
    for (int i = 0; i < TOP_K; i++) begin
      le[i]     = vld_q[i] && (sig_q[i] <= bus.in_signature);
      sh_sig[i] = '1;
      sh_idx[i] = '0;
    end
    // Slot 0 has nothing below it, so it is always at or above the insert point
    prev_le[0] = 1'b1;
    for (int i = 1; i < TOP_K; i++) begin
      prev_le[i] = le[i-1];
      sh_sig[i]  = sig_q[i-1];
      sh_idx[i]  = idx_q[i-1];
    end
  end

  // Next-state: insert/shift in COLLECT, hold then clear in OUTPUT
  always_comb begin
    state_d     = state_q;
    vld_d       = vld_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    for (int i = 0; i < TOP_K; i++) begin
      sig_d[i] = sig_q[i];
      idx_d[i] = idx_q[i];
    end

    case (state_q)
      COLLECT: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (accept) begin
          // le is monotone (ones then zeros), so the first zero is the insert
          // point; everything above it moves up and the top slot falls off.
          // A beat that loses to a full table leaves le all-ones: no change.
          for (int i = 0; i < TOP_K; i++) begin
            if (!le[i]) begin
              if (prev_le[i]) begin
                sig_d[i] = bus.in_signature;
                idx_d[i] = bus.in_index;
                vld_d[i] = 1'b1;
              end else begin
                sig_d[i] = sh_sig[i];
                idx_d[i] = sh_idx[i];
                vld_d[i] = vld_q[i-1 < 0 ? 0 : i-1];
              end
            end
          end
          if (bus.in_last) begin
            state_d     = OUTPUT;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      OUTPUT: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          state_d     = COLLECT;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          vld_d       = '0;
          for (int i = 0; i < TOP_K; i++) begin
            sig_d[i] = '1;
            idx_d[i] = '0;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Occupancy count follows the next valid bits so it is registered with them
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < TOP_K; i++) begin
      cnt_d = cnt_d + CNT_W'(vld_d[i]);
    end
  end

  // State, slot table and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      vld_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      for (int i = 0; i < TOP_K; i++) begin
        sig_q[i] <= '1;
        idx_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < TOP_K; i++) begin
        sig_q[i] <= sig_d[i];
        idx_q[i] <= idx_d[i];
      end
    end
  end

  // Flatten the slot table onto the result bus; pure wiring from registers
  logic [TOP_K*SIG_W-1:0] sig_flat;
  logic [TOP_K*IDX_W-1:0] idx_flat;
  always_comb begin
    sig_flat = '0;
    idx_flat = '0;
    for (int i = 0; i < TOP_K; i++) begin
      sig_flat[i*SIG_W +: SIG_W] = sig_q[i];
      idx_flat[i*IDX_W +: IDX_W] = idx_q[i];
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_signatures = sig_flat;
  assign bus.out_indices    = idx_flat;
  assign bus.out_count      = cnt_q;

endmodule
